// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel-strobe divider, H/V counters, sync/blank decodes and VBLANK interrupt.
// Optional `VT_LINE_IRQ_EN adds a programmable line-compare interrupt (irq_line/lineint_b/lineack_b).
module video_timing_gen #(
    parameter int CE_DIV       = 14,
    parameter int HW           = 9,
    parameter int VW           = 9,
    parameter int H_TOTAL      = 456,
    parameter int H_ACTIVE     = 336,
    parameter int H_SYNC_START = 376,
    parameter int H_SYNC_WIDTH = 32,
    parameter int V_TOTAL      = 262,
    parameter int V_ACTIVE     = 240,
    parameter int V_SYNC_START = 244,
    parameter int V_SYNC_WIDTH = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vbkack_b,
`ifdef VT_LINE_IRQ_EN
    input  logic [VW-1:0] irq_line,
    input  logic          lineack_b,
    output logic          lineint_b,
`endif
    output logic          pix_ce,
    output logic [HW-1:0] hcount,
    output logic [VW-1:0] vcount,
    output logic          hsync,
    output logic          vsync,
    output logic          hblank_b,
    output logic          vblank_b,
    output logic          nxl_b,
    output logic          vreset_b,
    output logic          vbkint_b
);

    localparam int CW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam logic [CW-1:0] CE_LAST  = CW'(CE_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    // One extra bit so a sync window ending exactly at 2**HW / 2**VW still compares correctly
    localparam logic [HW:0]   HS_BEG   = (HW+1)'(H_SYNC_START);
    localparam logic [HW:0]   HS_END   = (HW+1)'(H_SYNC_START + H_SYNC_WIDTH);
    localparam logic [VW:0]   VS_BEG   = (VW+1)'(V_SYNC_START);
    localparam logic [VW:0]   VS_END   = (VW+1)'(V_SYNC_START + V_SYNC_WIDTH);

    if (CE_DIV < 1) begin : g_bad_ce
        $error("video_timing_gen: CE_DIV must be >= 1");
    end
    if (H_SYNC_START + H_SYNC_WIDTH > H_TOTAL) begin : g_bad_hsync
        $error("video_timing_gen: hsync window exceeds H_TOTAL");
    end
    if (V_SYNC_START + V_SYNC_WIDTH > V_TOTAL) begin : g_bad_vsync
        $error("video_timing_gen: vsync window exceeds V_TOTAL");
    end
    if (H_ACTIVE >= H_TOTAL) begin : g_bad_hact
        $error("video_timing_gen: H_ACTIVE must be below H_TOTAL");
    end
    if (V_ACTIVE >= V_TOTAL) begin : g_bad_vact
        $error("video_timing_gen: V_ACTIVE must be below V_TOTAL");
    end
    if (H_TOTAL > (1 << HW)) begin : g_bad_hw
        $error("video_timing_gen: H_TOTAL does not fit in HW bits");
    end
    if (V_TOTAL > (1 << VW)) begin : g_bad_vw
        $error("video_timing_gen: V_TOTAL does not fit in VW bits");
    end

    logic [CW-1:0] ce_cnt_q, ce_cnt_d;
    logic          pix_ce_q, pix_ce_d;
    logic [HW-1:0] hcount_q, hcount_d;
    logic [VW-1:0] vcount_q, vcount_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          hblank_b_q, hblank_b_d;
    logic          vblank_b_q, vblank_b_d;
    logic          nxl_b_q, nxl_b_d;
    logic          vreset_b_q, vreset_b_d;
    logic          vbkint_b_q, vbkint_b_d;
    logic          line_start;
    logic [HW:0]   hx;
    logic [VW:0]   vx;

    always_comb begin
        ce_cnt_d   = (ce_cnt_q == CE_LAST) ? '0 : ce_cnt_q + 1'b1;
        pix_ce_d   = (ce_cnt_d == CE_LAST);
        hcount_d   = hcount_q;
        vcount_d   = vcount_q;
        line_start = 1'b0;
        if (pix_ce_q) begin
            if (hcount_q == H_LAST) begin
                hcount_d   = '0;
                line_start = 1'b1;
                vcount_d   = (vcount_q == V_LAST) ? '0 : vcount_q + 1'b1;
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
        end

        // Decode from the next counts so every flag lines up with the counter it describes
        hx         = {1'b0, hcount_d};
        vx         = {1'b0, vcount_d};
        hsync_d    = (hx >= HS_BEG) && (hx < HS_END);
        vsync_d    = (vx >= VS_BEG) && (vx < VS_END);
        hblank_b_d = (hcount_d < H_ACT);
        vblank_b_d = (vcount_d < V_ACT);
        nxl_b_d    = (hcount_d != H_LAST);
        vreset_b_d = !((hcount_d == H_LAST) && (vcount_d == V_LAST));

        // Ack releases the interrupt; a new set in the same clk overrides it
        vbkint_b_d = vbkint_b_q;
        if (!vbkack_b) vbkint_b_d = 1'b1;
        if (line_start && (vcount_d == V_ACT)) vbkint_b_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ce_cnt_q   <= '0;
            pix_ce_q   <= 1'b0;
            hcount_q   <= '0;
            vcount_q   <= '0;
            hsync_q    <= 1'b0;
            vsync_q    <= 1'b0;
            hblank_b_q <= 1'b1;
            vblank_b_q <= 1'b1;
            nxl_b_q    <= 1'b1;
            vreset_b_q <= 1'b1;
            vbkint_b_q <= 1'b1;
        end else begin
            ce_cnt_q   <= ce_cnt_d;
            pix_ce_q   <= pix_ce_d;
            hcount_q   <= hcount_d;
            vcount_q   <= vcount_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            hblank_b_q <= hblank_b_d;
            vblank_b_q <= vblank_b_d;
            nxl_b_q    <= nxl_b_d;
            vreset_b_q <= vreset_b_d;
            vbkint_b_q <= vbkint_b_d;
        end
    end

`ifdef VT_LINE_IRQ_EN
    logic lineint_b_q, lineint_b_d;

    // irq_line beyond the frame never matches since vcount never reaches it
    always_comb begin
        lineint_b_d = lineint_b_q;
        if (!lineack_b) lineint_b_d = 1'b1;
        if (line_start && (vcount_d == irq_line)) lineint_b_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) lineint_b_q <= 1'b1;
        else       lineint_b_q <= lineint_b_d;
    end

    assign lineint_b = lineint_b_q;
`endif

    assign pix_ce   = pix_ce_q;
    assign hcount   = hcount_q;
    assign vcount   = vcount_q;
    assign hsync    = hsync_q;
    assign vsync    = vsync_q;
    assign hblank_b = hblank_b_q;
    assign vblank_b = vblank_b_q;
    assign nxl_b    = nxl_b_q;
    assign vreset_b = vreset_b_q;
    assign vbkint_b = vbkint_b_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a small raster; reference derives every output from elapsed clks.
module tb_video_timing_gen;
    localparam int CE  = 3;
    localparam int HW  = 5;
    localparam int VW  = 4;
    localparam int HT  = 32;
    localparam int HA  = 24;
    localparam int HSS = 28;
    localparam int HSW = 4;
    localparam int VT  = 10;
    localparam int VA  = 6;
    localparam int VSS = 7;
    localparam int VSW = 2;
    localparam int FR  = HT * VT * CE;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic vbkack_b = 1'b1;
    logic pix_ce, hsync, vsync, hblank_b, vblank_b, nxl_b, vreset_b, vbkint_b;
    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
`ifdef VT_LINE_IRQ_EN
    logic [VW-1:0] irq_line = '0;
    logic lineack_b = 1'b1;
    logic lineint_b;
`endif

    always #5 clk = ~clk;

    video_timing_gen #(
        .CE_DIV(CE), .HW(HW), .VW(VW),
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_WIDTH(HSW),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_WIDTH(VSW)
    ) dut (
        .clk(clk), .reset(reset), .vbkack_b(vbkack_b),
`ifdef VT_LINE_IRQ_EN
        .irq_line(irq_line), .lineack_b(lineack_b), .lineint_b(lineint_b),
`endif
        .pix_ce(pix_ce), .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
        .hblank_b(hblank_b), .vblank_b(vblank_b), .nxl_b(nxl_b), .vreset_b(vreset_b),
        .vbkint_b(vbkint_b)
    );

    int checks = 0;
    int failures = 0;
    // Reference state: clk edges since reset release, plus interrupt levels
    int   t = 0;
    logic vbk_m = 1'b1;
    logic line_m = 1'b1;

    function automatic int m_pix();  return (t > 0 && t % CE == CE - 1) ? 1 : 0; endfunction
    function automatic int m_hc();   return (t / CE) % HT; endfunction
    function automatic int m_vc();   return (t / CE / HT) % VT; endfunction
    function automatic logic m_hsync(); return m_hc() >= HSS && m_hc() < HSS + HSW; endfunction
    function automatic logic m_vsync(); return m_vc() >= VSS && m_vc() < VSS + VSW; endfunction
    function automatic logic m_vrst_b(); return !(m_hc() == HT-1 && m_vc() == VT-1); endfunction

    // Advance one clk; inputs are sampled as they stand at the edge
    task automatic step();
        logic r, a, la;
        int   nold, nnew, vc, il;
        logic nl;
        r = reset; a = vbkack_b; la = 1'b1; il = -1;
`ifdef VT_LINE_IRQ_EN
        la = lineack_b; il = int'(irq_line);
`endif
        @(posedge clk);
        if (r) begin
            t = 0; vbk_m = 1'b1; line_m = 1'b1;
        end else begin
            nold = t / CE;
            t++;
            nnew = t / CE;
            nl   = (nnew != nold) && (nnew % HT == 0);
            vc   = (nnew / HT) % VT;
            if (!a) vbk_m = 1'b1;
            if (nl && vc == VA) vbk_m = 1'b0;
            if (!la) line_m = 1'b1;
            if (nl && vc == il) line_m = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        checks++;
        if ({pix_ce, hsync, vsync, hblank_b, vblank_b, nxl_b, vreset_b, vbkint_b} !== 8'b0001_1111) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00011111",
                     {pix_ce, hsync, vsync, hblank_b, vblank_b, nxl_b, vreset_b, vbkint_b});
        end
        checks++;
        if (hcount !== '0 || vcount !== '0) begin
            failures++;
            $display("FAIL reset_counts got h=%0d v=%0d exp 0/0", hcount, vcount);
        end
`ifdef VT_LINE_IRQ_EN
        checks++;
        if (lineint_b !== 1'b1) begin failures++; $display("FAIL reset_lineint got=%b exp=1", lineint_b); end
`endif
    endtask

    task automatic test_pix_ce();
        int first;
        first = -1;
        reset = 1'b0;
        for (int i = 0; i < 5 * CE; i++) begin
            step();
            if (pix_ce === 1'b1 && first < 0) first = t;
            checks++;
            if (pix_ce !== 1'(m_pix()) || 32'(hcount) !== m_hc()) begin
                failures++;
                $display("FAIL pix_ce t=%0d got ce=%b h=%0d exp ce=%0d h=%0d", t, pix_ce, hcount, m_pix(), m_hc());
            end
        end
        checks++;
        if (first != CE - 1) begin failures++; $display("FAIL first_pix_ce got=%0d exp=%0d", first, CE - 1); end
    endtask

    task automatic test_line_scan();
        int nxl_lows;
        nxl_lows = 0;
        for (int i = 0; i < 3 * HT * CE; i++) begin
            step();
            if (nxl_b === 1'b0 && pix_ce === 1'b1) nxl_lows++;
            checks++;
            if (32'(hcount) !== m_hc() || 32'(vcount) !== m_vc() || hsync !== m_hsync() ||
                hblank_b !== (m_hc() < HA) || nxl_b !== (m_hc() != HT - 1)) begin
                failures++;
                $display("FAIL line_scan t=%0d got h=%0d v=%0d hs=%b hb=%b nxl=%b exp h=%0d v=%0d hs=%b hb=%b nxl=%b",
                         t, hcount, vcount, hsync, hblank_b, nxl_b,
                         m_hc(), m_vc(), m_hsync(), m_hc() < HA, m_hc() != HT - 1);
            end
        end
        checks++;
        if (nxl_lows != 3) begin failures++; $display("FAIL nxl_count got=%0d exp=3", nxl_lows); end
    endtask

    task automatic test_frame_vbk();
        int last_fall, periods;
        logic prev_vr;
        last_fall = -1; periods = 0; prev_vr = vreset_b;
        vbkack_b = 1'b1;
        for (int i = 0; i < 2 * FR + 50; i++) begin
            step();
            checks++;
            if (32'(vcount) !== m_vc() || vsync !== m_vsync() || vblank_b !== (m_vc() < VA) ||
                vreset_b !== m_vrst_b() || vbkint_b !== vbk_m) begin
                failures++;
                $display("FAIL frame t=%0d got v=%0d vs=%b vb=%b vr=%b int=%b exp v=%0d vs=%b vb=%b vr=%b int=%b",
                         t, vcount, vsync, vblank_b, vreset_b, vbkint_b,
                         m_vc(), m_vsync(), m_vc() < VA, m_vrst_b(), vbk_m);
            end
            if (prev_vr === 1'b1 && vreset_b === 1'b0) begin
                if (last_fall >= 0) begin
                    periods++;
                    checks++;
                    if (t - last_fall != FR) begin
                        failures++;
                        $display("FAIL vreset_period got=%0d exp=%0d", t - last_fall, FR);
                    end
                end
                last_fall = t;
            end
            prev_vr = vreset_b;
        end
        checks++;
        if (periods < 1 || vbkint_b !== 1'b0) begin
            failures++;
            $display("FAIL vbk_held got periods=%0d int=%b exp >=1 and 0", periods, vbkint_b);
        end
        vbkack_b = 1'b0;
        step();
        vbkack_b = 1'b1;
        checks++;
        if (vbkint_b !== 1'b1) begin failures++; $display("FAIL vbk_ack got=%b exp=1", vbkint_b); end
    endtask

    task automatic test_random_ack();
        int lows;
        for (int i = 0; i < 3 * FR; i++) begin
            vbkack_b = ($urandom_range(0, 40) != 0);
            step();
            checks++;
            if (vbkint_b !== vbk_m || vblank_b !== (m_vc() < VA)) begin
                failures++;
                $display("FAIL random_ack t=%0d got int=%b vb=%b exp int=%b vb=%b",
                         t, vbkint_b, vblank_b, vbk_m, m_vc() < VA);
            end
        end
        // Ack held low through a whole frame: the set still wins for exactly one clk
        vbkack_b = 1'b0;
        step();
        lows = 0;
        for (int i = 0; i < FR; i++) begin
            step();
            if (vbkint_b === 1'b0) lows++;
        end
        vbkack_b = 1'b1;
        checks++;
        if (lows != 1) begin failures++; $display("FAIL set_beats_ack got=%0d exp=1", lows); end
    endtask

    task automatic test_reset_mid();
        int budget;
        budget = 0;
        while (m_vc() != VT / 2 && budget < 2 * FR) begin
            step();
            budget++;
        end
        checks++;
        if (32'(vcount) !== m_vc() || m_vc() != VT / 2) begin
            failures++;
            $display("FAIL mid_reach got v=%0d exp=%0d", vcount, VT / 2);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({pix_ce, hsync, vsync, hblank_b, vblank_b, nxl_b, vreset_b, vbkint_b} !== 8'b0001_1111 ||
            hcount !== '0 || vcount !== '0) begin
            failures++;
            $display("FAIL mid_reset got h=%0d v=%0d flags=%b exp 0 0 00011111", hcount, vcount,
                     {pix_ce, hsync, vsync, hblank_b, vblank_b, nxl_b, vreset_b, vbkint_b});
        end
        for (int i = 0; i < 4 * CE; i++) begin
            step();
            checks++;
            if (pix_ce !== 1'(m_pix()) || 32'(hcount) !== m_hc() || 32'(vcount) !== m_vc()) begin
                failures++;
                $display("FAIL restart t=%0d got ce=%b h=%0d v=%0d exp ce=%0d h=%0d v=%0d",
                         t, pix_ce, hcount, vcount, m_pix(), m_hc(), m_vc());
            end
        end
    endtask

`ifdef VT_LINE_IRQ_EN
    task automatic test_line_irq();
        int lows;
        irq_line = VW'($urandom_range(0, VT - 1));
        for (int i = 0; i < 2 * FR; i++) begin
            lineack_b = ($urandom_range(0, 30) != 0);
            step();
            checks++;
            if (lineint_b !== line_m) begin
                failures++;
                $display("FAIL line_irq t=%0d line=%0d got=%b exp=%b", t, irq_line, lineint_b, line_m);
            end
        end
        lineack_b = 1'b0;
        step();
        lows = 0;
        for (int i = 0; i < FR; i++) begin
            step();
            if (lineint_b === 1'b0) lows++;
        end
        checks++;
        if (lows != 1) begin failures++; $display("FAIL line_set_beats_ack got=%0d exp=1", lows); end
        irq_line = VW'(VT + 2);
        lineack_b = 1'b1;
        lows = 0;
        for (int i = 0; i < FR + 10; i++) begin
            step();
            if (lineint_b === 1'b0) lows++;
        end
        checks++;
        if (lows != 0) begin failures++; $display("FAIL line_out_of_range got=%0d exp=0", lows); end
    endtask
`endif

    initial begin
        test_reset();
        test_pix_ce();
        test_line_scan();
        test_frame_vbk();
        test_random_ack();
        test_reset_mid();
`ifdef VT_LINE_IRQ_EN
        test_line_irq();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
